// File: rtl/hazard_pkg.sv
// Shared forwarding-mux encodings for the hazard unit.
// The select value 2'b11 is reserved and never produced.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding select. Memory stage wins over Writeback.
// Latency: zero (combinational). Backpressure: none.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic match_m,
    input  logic match_w,
    input  logic reg_write_m,
    input  logic reg_write_w,
    output fwd_t sel
);

    always_comb begin
        sel = FWD_RF;
        if (match_m && reg_write_m) begin
            sel = FWD_MEM;
        end else if (match_w && reg_write_w) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_u.sv
// Pipeline hazard unit: forwarding selects, load-use stall, saturating event counters.
// Latency: controls are combinational; counters and ldr_stall_q update on clk. Backpressure: none.
module hazard_u
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteW,
    input  logic             RegWriteM,
    input  logic             MemtoRegE,
    input  logic             Match_1E_M,
    input  logic             Match_1E_W,
    input  logic             Match_2E_M,
    input  logic             Match_2E_W,
    input  logic             Match_12D_E,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             LDRstall,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwdM_cnt,
    output logic [CNT_W-1:0] fwdW_cnt,
    output logic             ldr_stall_q
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    fwd_t sel_a;
    fwd_t sel_b;
    logic fwd_mem_evt;
    logic fwd_wb_evt;

    fwd_sel u_fwd_a (
        .match_m     (Match_1E_M),
        .match_w     (Match_1E_W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (sel_a)
    );

    fwd_sel u_fwd_b (
        .match_m     (Match_2E_M),
        .match_w     (Match_2E_W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (sel_b)
    );

    assign ForwardAE = sel_a;
    assign ForwardBE = sel_b;
    assign LDRstall  = Match_12D_E & MemtoRegE;
    assign StallF    = LDRstall;
    assign StallD    = LDRstall;
    assign FlushE    = LDRstall;

    // One event per cycle per stage, even when both operands forward from it.
    assign fwd_mem_evt = (sel_a == FWD_MEM) || (sel_b == FWD_MEM);
    assign fwd_wb_evt  = !fwd_mem_evt && ((sel_a == FWD_WB) || (sel_b == FWD_WB));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt   <= '0;
            fwdM_cnt    <= '0;
            fwdW_cnt    <= '0;
            ldr_stall_q <= 1'b0;
        end else begin
            ldr_stall_q <= LDRstall;
            if (LDRstall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (fwd_mem_evt && fwdM_cnt != CNT_MAX) begin
                fwdM_cnt <= fwdM_cnt + CNT_ONE;
            end
            if (fwd_wb_evt && fwdW_cnt != CNT_MAX) begin
                fwdW_cnt <= fwdW_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_u.sv
// Scoreboard bench for hazard_u: expected {ForwardAE, ForwardBE, LDRstall} queued at drive time.
module tb_hazard_u;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             RegWriteW, RegWriteM, MemtoRegE;
    logic             Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             LDRstall, StallF, StallD, FlushE;
    logic [CNT_W-1:0] stall_cnt, fwdM_cnt, fwdW_cnt;
    logic             ldr_stall_q;

    int checks   = 0;
    int failures = 0;

    logic [4:0]       exp_q[$];
    logic [CNT_W-1:0] m_stall, m_fm, m_fw;
    logic             m_ldr_q;

    hazard_u #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWriteW   (RegWriteW),
        .RegWriteM   (RegWriteM),
        .MemtoRegE   (MemtoRegE),
        .Match_1E_M  (Match_1E_M),
        .Match_1E_W  (Match_1E_W),
        .Match_2E_M  (Match_2E_M),
        .Match_2E_W  (Match_2E_W),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .Match_12D_E (Match_12D_E),
        .LDRstall    (LDRstall),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushE      (FlushE),
        .stall_cnt   (stall_cnt),
        .fwdM_cnt    (fwdM_cnt),
        .fwdW_cnt    (fwdW_cnt),
        .ldr_stall_q (ldr_stall_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // v = {RegWriteW, RegWriteM, MemtoRegE, M1E_M, M1E_W, M2E_M, M2E_W, M12D_E}
    task automatic drive(input logic [7:0] v);
        {RegWriteW, RegWriteM, MemtoRegE, Match_1E_M, Match_1E_W,
         Match_2E_M, Match_2E_W, Match_12D_E} = v;
    endtask

    function automatic logic [4:0] model(input logic [7:0] v);
        logic [1:0] fa, fb;
        fa = (v[4] && v[6]) ? 2'b10 : (v[3] && v[7]) ? 2'b01 : 2'b00;
        fb = (v[2] && v[6]) ? 2'b10 : (v[1] && v[7]) ? 2'b01 : 2'b00;
        return {fa, fb, v[5] & v[0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] all_ones();
        return {CNT_W{1'b1}};
    endfunction

    task automatic check_counters(input string tag);
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, ".fwdM_cnt"}, 32'(fwdM_cnt), 32'(m_fm));
        check({tag, ".fwdW_cnt"}, 32'(fwdW_cnt), 32'(m_fw));
        check({tag, ".ldr_stall_q"}, 32'(ldr_stall_q), 32'(m_ldr_q));
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input string tag, input logic [7:0] v, input logic [4:0] exp5);
        logic [4:0] e;
        drive(v);
        exp_q.push_back(exp5);
        #2;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".result"}, 32'({ForwardAE, ForwardBE, LDRstall}), 32'(e));
            check({tag, ".stall_ctl"}, 32'({StallF, StallD, FlushE}), 32'({3{e[0]}}));
            @(posedge clk);
            if (e[0]) m_stall = sat_inc(m_stall);
            if (e[4:3] == 2'b10 || e[2:1] == 2'b10) m_fm = sat_inc(m_fm);
            else if (e[4:3] == 2'b01 || e[2:1] == 2'b01) m_fw = sat_inc(m_fw);
            m_ldr_q = e[0];
            #1;
            check_counters(tag);
        end
    endtask

    initial begin
        logic [7:0] v;
        m_stall = '0; m_fm = '0; m_fw = '0; m_ldr_q = 1'b0;
        reset = 1'b0;
        drive(8'h00);
        #3;
        check_counters("reset");
        // Combinational path stays live while reset is held.
        drive(8'b0010_0001);
        #1;
        check("reset.comb_ldrstall", 32'(LDRstall), 32'd1);
        drive(8'b1101_0010);
        #1;
        check("reset.comb_fwd", 32'({ForwardAE, ForwardBE, LDRstall}), 32'b10010);
        drive(8'h00);
        #7;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_counters("post_reset");

        step("all_zero", 8'b0000_0000, 5'b00000);
        step("mem_prio", 8'b1101_1010, 5'b10010);
        step("no_write", 8'b1001_0100, 5'b00000);
        for (int i = 0; i < 3; i++) step("ldr_stall", 8'b0010_0001, 5'b00001);
        check("ldr_stall.cnt3", 32'(stall_cnt), 32'd3);
        step("ldr_release", 8'b0000_0000, 5'b00000);
        step("both_mem", 8'b0101_0100, 5'b10100);
        step("both_wb", 8'b1000_1010, 5'b01010);
        step("mem_a_wb_b", 8'b1101_0010, 5'b10010);

        for (int i = 0; i < 60; i++) begin
            v = 8'($urandom);
            step("random", v, model(v));
        end

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step("sat_mem", 8'b0111_0001, 5'b10001);
            else            step("sat_wb", 8'b1010_1011, 5'b01011);
        end
        check("sat.stall_cnt", 32'(stall_cnt), 32'(all_ones()));
        check("sat.fwdM_cnt", 32'(fwdM_cnt), 32'(all_ones()));
        check("sat.fwdW_cnt", 32'(fwdW_cnt), 32'(all_ones()));

        // Asynchronous reset between edges while events continue.
        drive(8'b0111_0001);
        #2;
        reset = 1'b0;
        #1;
        m_stall = '0; m_fm = '0; m_fw = '0; m_ldr_q = 1'b0;
        check_counters("async_reset");
        check("async_reset.comb", 32'({ForwardAE, ForwardBE, LDRstall}), 32'b10001);
        @(posedge clk);
        #1;
        check_counters("reset_held");
        reset = 1'b1;
        step("resume", 8'b0010_0001, 5'b00001);
        step("resume2", 8'b1000_1000, 5'b01000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_u.md
HAZARD_U -- requirements
Module: hazard_u

Interface
REQ-001 Parameter CNT_W, default 16: width of the hazard event counters.
REQ-002 clk  input  1  rising-edge clock for the counter and status registers.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 RegWriteW  input  1  Writeback-stage instruction writes the register file.
REQ-005 RegWriteM  input  1  Memory-stage instruction writes the register file.
REQ-006 MemtoRegE  input  1  Execute-stage instruction is a load (LDR).
REQ-007 Match_1E_M  input  1  Execute source reg 1 equals Memory destination.
REQ-008 Match_1E_W  input  1  Execute source reg 1 equals Writeback destination.
REQ-009 Match_2E_M  input  1  Execute source reg 2 equals Memory destination.
REQ-010 Match_2E_W  input  1  Execute source reg 2 equals Writeback destination.
REQ-011 ForwardAE  output  2  operand-A mux select: 00 regfile, 01 Writeback result, 10 Memory ALU result.
REQ-012 ForwardBE  output  2  operand-B mux select, same encoding as ForwardAE.
REQ-013 Match_12D_E  input  1  a Decode source reg equals the Execute destination.
REQ-014 LDRstall  output  1  load-use stall request.
REQ-015 StallF, StallD, FlushE  output  1 each  pipeline control derived from LDRstall.
REQ-016 stall_cnt, fwdM_cnt, fwdW_cnt  output  CNT_W each  saturating event counters.
REQ-017 ldr_stall_q  output  1  LDRstall registered by one cycle.

Function
REQ-018 ForwardAE SHALL be 10 when Match_1E_M & RegWriteM; else 01 when Match_1E_W & RegWriteW; else 00 (Memory priority over Writeback).
REQ-019 ForwardBE SHALL follow REQ-018 using Match_2E_M and Match_2E_W.
REQ-020 Encoding 11 SHALL never be driven.
REQ-021 LDRstall SHALL equal Match_12D_E & MemtoRegE.
REQ-022 StallF and StallD SHALL equal LDRstall; FlushE SHALL equal LDRstall.
REQ-023 ForwardAE, ForwardBE, LDRstall, StallF, StallD and FlushE SHALL be purely combinational (zero latency) and independent of clk and reset.
REQ-024 stall_cnt SHALL increment on each rising edge where LDRstall=1, saturating at all-ones.
REQ-025 fwdM_cnt SHALL increment on each edge where either select equals 10; fwdW_cnt SHALL increment where either equals 01 and neither equals 10. Both saturate.
REQ-026 A cycle with both operands forwarding from the same stage SHALL count once.
REQ-027 ldr_stall_q SHALL capture LDRstall on each rising edge.

Reset
REQ-028 reset low SHALL asynchronously clear stall_cnt, fwdM_cnt, fwdW_cnt and ldr_stall_q to 0.
REQ-029 Combinational outputs SHALL remain valid during reset.
REQ-030 Counters SHALL resume from 0 on the first rising edge after reset deassertion.

Structure
REQ-031 The forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) SHALL live in a shared package, hazard_pkg.
REQ-032 One sub-module, fwd_sel, SHALL implement REQ-018 and SHALL be instantiated twice, once for operand A and once for operand B.
REQ-033 Counters SHALL be implemented inline in hazard_u.

Verification
REQ-034 The bench SHALL sample the result {ForwardAE, ForwardBE, LDRstall} as a 5-bit value.
REQ-035 All inputs 0 -> 00000; counters unchanged.
REQ-036 RegWriteW=1, RegWriteM=1, Match_1E_M=1, Match_1E_W=1, Match_2E_W=1 -> 10010 (Memory priority on A, Writeback on B).
REQ-037 RegWriteM=0, RegWriteW=1, Match_1E_M=1, Match_2E_M=1 -> 00000 (no write, no forward).
REQ-038 MemtoRegE=1, Match_12D_E=1 for 3 cycles -> LDRstall=1, StallF=StallD=FlushE=1, stall_cnt=3, ldr_stall_q follows one cycle later.
REQ-039 All counters held at all-ones with events continuing -> counters stay all-ones; reset low mid-run -> counters and ldr_stall_q clear immediately, without waiting for a clock edge.
